// File: rtl/logic_clock_domain_crossing_arbiter.sv
// Packet-aware round-robin arbiter feeding one CDC FIFO write port.
// Whole tlast-delimited packets are granted atomically; source id rides on tx_tid.
module logic_clock_domain_crossing_arbiter #(
   parameter int INPUTS   = 2,
   parameter int WIDTH    = 1,
   parameter int ID_WIDTH = $clog2(INPUTS)
) (
   input  logic                           aclk,
   input  logic                           areset_n,
   input  logic [INPUTS-1:0]              rx_tvalid,
   input  logic [INPUTS-1:0]              rx_tlast,
   input  logic [INPUTS-1:0][WIDTH-1:0]   rx_tdata,
   output logic [INPUTS-1:0]              rx_tready,
   input  logic                           tx_tready,
   output logic                           tx_tvalid,
   output logic                           tx_tlast,
   output logic [ID_WIDTH-1:0]            tx_tid,
   output logic [WIDTH-1:0]               tx_tdata
);

   typedef enum logic {IDLE, LOCKED} state_e;

   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(INPUTS - 1);

   state_e              state_q, state_d;
   logic [ID_WIDTH-1:0] ptr_q, ptr_d;
   logic [ID_WIDTH-1:0] grant_q, grant_d;
   logic                tvalid_q, tvalid_d;
   logic                tlast_q, tlast_d;
   logic [ID_WIDTH-1:0] tid_q, tid_d;
   logic [WIDTH-1:0]    tdata_q, tdata_d;

   logic [ID_WIDTH-1:0] pick;
   logic                slot_free;
   logic                accept;

   // First valid requester at or after the pointer, wrapping by compare
   always_comb begin
      int  idx;
      logic found;
      pick  = ptr_q;
      found = 1'b0;
      for (int k = 0; k < INPUTS; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= INPUTS) idx = idx - INPUTS;
         if (!found && rx_tvalid[idx[ID_WIDTH-1:0]]) begin
            found = 1'b1;
            pick  = idx[ID_WIDTH-1:0];
         end
      end
   end

   assign slot_free = !tvalid_q || tx_tready;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      rx_tready = '0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|rx_tvalid) begin
               state_d = LOCKED;
               grant_d = pick;
            end
         end
         LOCKED: begin
            if (slot_free) rx_tready[grant_q] = 1'b1;
            accept = slot_free && rx_tvalid[grant_q];
            if (accept && rx_tlast[grant_q]) begin
               state_d = IDLE;
               if (grant_q == LAST_ID) ptr_d = '0;
               else                    ptr_d = grant_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register holds its beat until the FIFO takes it
   always_comb begin
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tid_d    = tid_q;
      tdata_d  = tdata_q;
      if (accept) begin
         tvalid_d = 1'b1;
         tlast_d  = rx_tlast[grant_q];
         tid_d    = grant_q;
         tdata_d  = rx_tdata[grant_q];
      end else if (tx_tready) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tid_q    <= '0;
         tdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tid_q    <= tid_d;
         tdata_q  <= tdata_d;
      end
   end

   assign tx_tvalid = tvalid_q;
   assign tx_tlast  = tlast_q;
   assign tx_tid    = tid_q;
   assign tx_tdata  = tdata_q;

endmodule

// File: tb/tb_logic_clock_domain_crossing_arbiter.sv
// Directed bench for the packet round-robin CDC arbiter.
// Four-input instance for most cases, three-input instance for wrap/skip.
module tb_logic_clock_domain_crossing_arbiter;

   logic aclk = 1'b0;
   logic areset_n = 1'b1;
   always #5 aclk = ~aclk;

   logic [3:0]       rx_tvalid, rx_tlast, rx_tready;
   logic [3:0][7:0]  rx_tdata;
   logic             tx_tready, tx_tvalid, tx_tlast;
   logic [1:0]       tx_tid;
   logic [7:0]       tx_tdata;

   logic [2:0]       v3, l3, rdy3;
   logic [2:0][7:0]  d3;
   logic             tx3_tready, tx3_tvalid, tx3_tlast;
   logic [1:0]       tx3_tid;
   logic [7:0]       tx3_tdata;

   logic_clock_domain_crossing_arbiter #(.INPUTS(4), .WIDTH(8)) dut4 (
      .aclk(aclk), .areset_n(areset_n),
      .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
      .rx_tdata(rx_tdata), .rx_tready(rx_tready),
      .tx_tready(tx_tready), .tx_tvalid(tx_tvalid),
      .tx_tlast(tx_tlast), .tx_tid(tx_tid), .tx_tdata(tx_tdata)
   );

   logic_clock_domain_crossing_arbiter #(.INPUTS(3), .WIDTH(8)) dut3 (
      .aclk(aclk), .areset_n(areset_n),
      .rx_tvalid(v3), .rx_tlast(l3),
      .rx_tdata(d3), .rx_tready(rdy3),
      .tx_tready(tx3_tready), .tx_tvalid(tx3_tvalid),
      .tx_tlast(tx3_tlast), .tx_tid(tx3_tid), .tx_tdata(tx3_tdata)
   );

   int ntest = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      ntest++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // per-requester beat sources
   logic [7:0] bd [4][64];
   logic       bl [4][64];
   int         rp [4];
   int         wp [4];

   // accepted tx beats
   logic [1:0] lg_tid [64];
   logic [7:0] lg_dat [64];
   logic       lg_lst [64];
   int         lg_cyc [64];
   int         nrx;
   int         cyc;
   logic       bp;

   logic       pv_stall, pv_l;
   logic [7:0] pv_d;
   logic [1:0] pv_t;

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         rx_tvalid[i] = (rp[i] != wp[i]);
         rx_tdata[i]  = bd[i][rp[i]];
         rx_tlast[i]  = bl[i][rp[i]];
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < 4; i++) begin
         rp[i] = 0;
         wp[i] = 0;
      end
      drive();
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      bd[i][wp[i]] = d;
      bl[i][wp[i]] = l;
      wp[i]++;
      drive();
   endtask

   task automatic step();
      logic [3:0] fire;
      @(negedge aclk);
      if (pv_stall) begin
         chk("stall_valid", tx_tvalid, 1);
         chk("stall_data", tx_tdata, pv_d);
         chk("stall_last", tx_tlast, pv_l);
         chk("stall_tid", tx_tid, pv_t);
      end
      pv_stall = tx_tvalid && !tx_tready;
      pv_d = tx_tdata;
      pv_l = tx_tlast;
      pv_t = tx_tid;
      if (tx_tvalid && tx_tready && nrx < 64) begin
         lg_tid[nrx] = tx_tid;
         lg_dat[nrx] = tx_tdata;
         lg_lst[nrx] = tx_tlast;
         lg_cyc[nrx] = cyc;
         nrx++;
      end
      fire = rx_tvalid & rx_tready;
      cyc++;
      @(posedge aclk);
      #1;
      for (int i = 0; i < 4; i++)
         if (fire[i]) rp[i]++;
      if (bp) tx_tready = ~tx_tready;
      drive();
   endtask

   task automatic run_until(input int n, input int budget);
      for (int k = 0; k < budget && nrx < n; k++) step();
      chk("rx_count", nrx, n);
   endtask

   task automatic do_reset();
      areset_n = 1'b0;
      clear_src();
      pv_stall = 1'b0;
      bp = 1'b0;
      tx_tready = 1'b1;
      step();
      step();
      areset_n = 1'b1;
      nrx = 0;
   endtask

   task automatic grant3(input string tag, input logic [2:0] v,
                         input logic [2:0] er, input logic [1:0] et);
      logic [2:0] r;
      r = '0;
      v3 = v;
      for (int k = 0; k < 20; k++) begin
         @(negedge aclk);
         r = rdy3;
         @(posedge aclk);
         #1;
         if (r != 0) break;
      end
      v3 = '0;
      chk({tag, "_rdy"}, r, er);
      @(negedge aclk);
      chk({tag, "_valid"}, tx3_tvalid, 1);
      chk({tag, "_tid"}, tx3_tid, et);
      chk({tag, "_data"}, tx3_tdata, 8'h30 + et);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 64; k++) begin
            bd[i][k] = '0;
            bl[i][k] = 1'b0;
         end
      nrx = 0;
      cyc = 0;
      bp = 1'b0;
      pv_stall = 1'b0;
      tx_tready = 1'b1;
      clear_src();
      v3 = '0;
      l3 = '1;
      for (int i = 0; i < 3; i++) d3[i] = 8'h30 + 8'(i);
      tx3_tready = 1'b1;
      #2;

      // reset with every requester valid
      areset_n = 1'b0;
      for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
      step();
      step();
      chk("rst_rx_tready", rx_tready, 0);
      chk("rst_tx_tvalid", tx_tvalid, 0);
      chk("rst_tx_tlast", tx_tlast, 0);
      chk("rst_tx_tid", tx_tid, 0);
      chk("rst_tx_tdata", tx_tdata, 0);
      chk("rst3_rdy", rdy3, 0);
      chk("rst3_valid", tx3_tvalid, 0);
      areset_n = 1'b1;
      nrx = 0;
      run_until(4, 40);
      for (int k = 0; k < 4; k++) begin
         chk("rst_order_tid", lg_tid[k], k);
         chk("rst_order_data", lg_dat[k], 8'h10 + k);
      end

      // round robin over single-beat packets
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 4; i++)
            push(i, 8'h20 + 8'(r * 4 + i), 1'b1);
      run_until(12, 80);
      for (int k = 0; k < 12; k++) begin
         chk("rr_tid", lg_tid[k], k % 4);
         chk("rr_data", lg_dat[k], 8'h20 + k);
         chk("rr_last", lg_lst[k], 1);
      end
      for (int k = 1; k < 12; k++)
         chk("rr_bubble", lg_cyc[k] - lg_cyc[k-1], 2);

      // packet atomicity: req1 five beats while req0 waits
      do_reset();
      push(0, 8'h50, 1'b1);
      run_until(1, 20);
      for (int b = 0; b < 5; b++) push(1, 8'h61 + 8'(b), b == 4);
      push(0, 8'h51, 1'b1);
      run_until(7, 60);
      for (int k = 1; k < 6; k++) begin
         chk("atom_tid", lg_tid[k], 1);
         chk("atom_data", lg_dat[k], 8'h60 + k);
         chk("atom_last", lg_lst[k], k == 5);
      end
      chk("atom_next_tid", lg_tid[6], 0);
      chk("atom_next_data", lg_dat[6], 8'h51);

      // backpressure with tx_tready toggling
      do_reset();
      bp = 1'b1;
      for (int b = 0; b < 4; b++) push(3, 8'h41 + 8'(b), b == 3);
      run_until(4, 60);
      repeat (6) step();
      chk("bp_count", nrx, 4);
      for (int k = 0; k < 4; k++) begin
         chk("bp_tid", lg_tid[k], 3);
         chk("bp_data", lg_dat[k], 8'h41 + k);
         chk("bp_last", lg_lst[k], k == 3);
      end
      bp = 1'b0;
      tx_tready = 1'b1;

      // wrap and skip on the three-input instance
      do_reset();
      grant3("wrap_a", 3'b010, 3'b010, 2'd1);
      grant3("wrap_b", 3'b010, 3'b010, 2'd1);
      grant3("wrap_c", 3'b101, 3'b100, 2'd2);

      // reset in the middle of a three-beat packet
      do_reset();
      push(2, 8'h81, 1'b0);
      push(2, 8'h82, 1'b0);
      push(2, 8'h83, 1'b1);
      for (int k = 0; k < 20 && rp[2] < 1; k++) step();
      chk("mid_first_beat", rp[2], 1);
      areset_n = 1'b0;
      #1;
      chk("mid_tx_tvalid", tx_tvalid, 0);
      chk("mid_rx_tready", rx_tready, 0);
      clear_src();
      pv_stall = 1'b0;
      step();
      step();
      areset_n = 1'b1;
      nrx = 0;
      push(1, 8'h71, 1'b1);
      push(3, 8'h73, 1'b1);
      run_until(2, 30);
      chk("mid_after_tid0", lg_tid[0], 1);
      chk("mid_after_data0", lg_dat[0], 8'h71);
      chk("mid_after_tid1", lg_tid[1], 3);
      chk("mid_after_data1", lg_dat[1], 8'h73);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
